// File: rtl/proj_fm_sweep_counter_if.sv
// Control/status bundle between the MinHash control FSM (master) and the
// FM buffer sweep counter (slave).
interface proj_fm_sweep_counter_if #(
   parameter int ADDR_W = 8,
   parameter int N_CH   = 4,
   parameter int PASS_W = 4
);
   logic                     in_start;
   logic                     in_enable;
   logic                     in_abort;
   logic [ADDR_W-1:0]        in_len;
   logic [PASS_W-1:0]        in_passes;
   logic [N_CH*ADDR_W-1:0]   out_index;
   logic                     out_busy;
   logic                     out_finished_count;
   logic [PASS_W-1:0]        out_pass;
   logic                     out_done;
   logic                     out_err;

   modport master (
      output in_start, in_enable, in_abort, in_len, in_passes,
      input  out_index, out_busy, out_finished_count, out_pass, out_done, out_err
   );

   modport slave (
      input  in_start, in_enable, in_abort, in_len, in_passes,
      output out_index, out_busy, out_finished_count, out_pass, out_done, out_err
   );
endinterface

// File: rtl/proj_fm_sweep_counter.sv
// Multi-channel FM buffer sweep counter. A shared base index runs 0..len for
// a programmed number of passes; each channel presents base + c wrapped into
// the same range so parallel hash lanes hit distinct FM slots every cycle.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for a start request; bad requests pulse out_err
// ST_RUN  | sweeping base while in_enable is high; out_busy high
// ST_DONE | one cycle after the final pass; returns to ST_IDLE
module proj_fm_sweep_counter #(
   parameter int ADDR_W = 8,
   parameter int N_CH   = 4,
   parameter int PASS_W = 4
) (
   input logic                     in_clk,
   input logic                     in_rst,
   proj_fm_sweep_counter_if.slave  bus
);
   localparam int IDX_W = N_CH * ADDR_W;
   localparam logic [ADDR_W:0] NCH_V = (ADDR_W+1)'(N_CH);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t               state;
   logic [ADDR_W-1:0]    base;
   logic [ADDR_W-1:0]    len_l;
   logic [PASS_W-1:0]    passes_l;
   logic [ADDR_W:0]      len_p1;
   logic                 start_ok;

   // Channel indices for a given base. Sums are one bit wider than the index
   // so len = all-ones cannot overflow; a single subtraction is enough because
   // an accepted len always satisfies len + 1 >= N_CH. len = 0 (only seen
   // straight after reset with N_CH > 1) maps every channel to 0.
   function automatic logic [IDX_W-1:0] chan_idx(input logic [ADDR_W-1:0] b,
                                                 input logic [ADDR_W-1:0] len);
      logic [ADDR_W:0] sum;
      logic [ADDR_W:0] lim;
      chan_idx = '0;
      lim = {1'b0, len} + {{ADDR_W{1'b0}}, 1'b1};
      for (int c = 0; c < N_CH; c++) begin
         sum = {1'b0, b} + (ADDR_W+1)'(c);
         if (len == '0)
            sum = '0;
         else if (sum >= lim)
            sum = sum - lim;
         chan_idx[c*ADDR_W +: ADDR_W] = sum[ADDR_W-1:0];
      end
   endfunction

   assign len_p1   = {1'b0, bus.in_len} + {{ADDR_W{1'b0}}, 1'b1};
   assign start_ok = (bus.in_passes != '0) && (len_p1 >= NCH_V);

   // Sweep FSM with registered outputs; pulses default low every cycle.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state                  <= ST_IDLE;
         base                   <= '0;
         len_l                  <= '0;
         passes_l               <= '0;
         bus.out_index          <= '0;
         bus.out_busy           <= 1'b0;
         bus.out_finished_count <= 1'b0;
         bus.out_pass           <= '0;
         bus.out_done           <= 1'b0;
         bus.out_err            <= 1'b0;
      end else begin
         bus.out_finished_count <= 1'b0;
         bus.out_done           <= 1'b0;
         bus.out_err            <= 1'b0;
         if (bus.in_abort) begin
            state         <= ST_IDLE;
            base          <= '0;
            bus.out_busy  <= 1'b0;
            bus.out_index <= chan_idx('0, len_l);
         end else begin
            case (state)
               ST_IDLE: begin
                  if (bus.in_start) begin
                     if (start_ok) begin
                        state         <= ST_RUN;
                        len_l         <= bus.in_len;
                        passes_l      <= bus.in_passes;
                        base          <= '0;
                        bus.out_pass  <= '0;
                        bus.out_busy  <= 1'b1;
                        bus.out_index <= chan_idx('0, bus.in_len);
                     end else begin
                        bus.out_err <= 1'b1;
                     end
                  end
               end
               ST_RUN: begin
                  if (bus.in_enable) begin
                     if (base == len_l) begin
                        base                   <= '0;
                        bus.out_pass           <= bus.out_pass + PASS_W'(1);
                        bus.out_finished_count <= 1'b1;
                        bus.out_index          <= chan_idx('0, len_l);
                        if (bus.out_pass + PASS_W'(1) == passes_l) begin
                           state        <= ST_DONE;
                           bus.out_busy <= 1'b0;
                           bus.out_done <= 1'b1;
                        end
                     end else begin
                        base          <= base + ADDR_W'(1);
                        bus.out_index <= chan_idx(base + ADDR_W'(1), len_l);
                     end
                  end
               end
               ST_DONE: begin
                  state <= ST_IDLE;
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end
endmodule
